// File: rtl/fp32_to_fp8_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_to_fp8_packer_pkg
// Description : Shared constants and types for the fp32 -> fp8 requantizer.
//               The fp8 operand word is 9 bits wide:
//               [8] sign, [7:4] exponent (bias 7), [3:0] mantissa.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_to_fp8_packer_pkg;

    // fp8 operand format
    localparam int          EXP_W       = 4;
    localparam int          MAN_W       = 4;
    localparam int          BIAS        = 7;
    localparam int          FP8_W       = EXP_W + MAN_W + 1;
    localparam logic [7:0]  FP8_MAX_MAG = 8'hFF;

    // IEEE-754 single-precision fields
    localparam int          FP32_W      = 32;
    localparam int          FP32_EXP_W  = 8;
    localparam int          FP32_MAN_W  = 23;
    localparam int          FP32_BIAS   = 127;

    typedef logic [FP8_W-1:0] fp8_t;

endpackage : fp32_to_fp8_packer_pkg
`default_nettype wire

// File: rtl/fp32_to_fp8_packer_cvt.sv
`default_nettype none
// ============================================================================
// Module      : fp32_to_fp8_cvt
// Description : Combinational single-value fp32 -> fp8 converter.
//               Round-to-nearest-even on the 4-bit mantissa, saturation to
//               +/-496 on overflow or Inf, flush-to-zero on underflow, zero
//               or subnormal input, NaN mapped to 9'h0FF.
// Ports       : fp32 - IEEE-754 single input
//               fp8  - converted fp8 operand word
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_to_fp8_cvt
    import fp32_to_fp8_packer_pkg::*;
(
    input  logic [FP32_W-1:0] fp32,
    output fp8_t              fp8
);

    localparam logic [9:0] c_EXP_SHIFT = 10'(FP32_BIAS - BIAS);
    localparam logic [9:0] c_E8_MAX    = 10'((1 << EXP_W) - 1);

    logic                    w_sign;
    logic [FP32_EXP_W-1:0]   w_exp;
    logic [FP32_MAN_W-1:0]   w_frac;
    logic [MAN_W-1:0]        w_mant;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_round_up;
    logic [MAN_W:0]          w_mant_sum;
    logic [9:0]              w_e8;
    logic                    w_exp_all_ones;
    logic                    w_exp_zero;
    logic                    w_is_nan;

    assign w_sign     = fp32[FP32_W-1];
    assign w_exp      = fp32[FP32_W-2 -: FP32_EXP_W];
    assign w_frac     = fp32[FP32_MAN_W-1:0];

    // Keep the top MAN_W fraction bits; the next bit is guard, the rest sticky.
    assign w_mant     = w_frac[FP32_MAN_W-1 -: MAN_W];
    assign w_guard    = w_frac[FP32_MAN_W-1-MAN_W];
    assign w_sticky   = |w_frac[FP32_MAN_W-2-MAN_W:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);

    // A carry out of the mantissa (1.1111 + ulp) leaves mantissa 0000 and
    // bumps the exponent by one.
    assign w_mant_sum = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_round_up};

    // Rebias in 10-bit two's complement so under/overflow are both visible.
    assign w_e8 = {2'b00, w_exp} + {9'd0, w_mant_sum[MAN_W]} - c_EXP_SHIFT;

    assign w_exp_all_ones = &w_exp;
    assign w_exp_zero     = (w_exp == '0);
    assign w_is_nan       = w_exp_all_ones & (|w_frac);

    always_comb begin
        fp8 = '0;
        if (w_is_nan) begin
            fp8 = {1'b0, FP8_MAX_MAG};
        end else if (w_exp_all_ones) begin
            fp8 = {w_sign, FP8_MAX_MAG};
        end else if (w_exp_zero) begin
            fp8 = '0;
        end else if ($signed(w_e8) > $signed(c_E8_MAX)) begin
            fp8 = {w_sign, FP8_MAX_MAG};
        end else if ($signed(w_e8) < $signed(10'sd1)) begin
            fp8 = '0;
        end else begin
            fp8 = {w_sign, w_e8[EXP_W-1:0], w_mant_sum[MAN_W-1:0]};
        end
    end

endmodule : fp32_to_fp8_cvt
`default_nettype wire

// File: rtl/fp32_to_fp8_packer.sv
`default_nettype none
// ============================================================================
// Module      : fp32_to_fp8_packer
// Description : Streaming requantizer. Converts one fp32 value per accept to
//               fp8 and packs LANES consecutive values into one output
//               vector. A flush closes a partial vector with zero padding.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - input handshake
//               in_data               - IEEE-754 single
//               flush                 - close the current vector
//               out_valid/out_ready   - output handshake
//               out_data              - lane i at [9i+8:9i], lane 0 first
//               out_last              - vector was closed by a flush
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_to_fp8_packer
    import fp32_to_fp8_packer_pkg::*;
#(
    parameter int LANES = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP32_W-1:0]      in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*FP8_W-1:0] out_data,
    output logic                   out_last
);

    localparam int                 c_IDX_W    = $clog2(LANES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LANES - 1);

    logic [c_IDX_W-1:0]     r_idx;
    fp8_t                   r_buf [LANES];
    logic                   r_flush_pend;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [LANES*FP8_W-1:0] r_out_data;

    fp8_t                   w_cvt;
    fp8_t                   w_buf_next [LANES];
    logic [LANES*FP8_W-1:0] w_buf_flat;
    logic                   w_last_lane;
    logic                   w_out_free;
    logic                   w_accept;
    logic                   w_flush_req;
    logic                   w_has_data;
    logic                   w_close;

    fp32_to_fp8_cvt u_cvt (
        .fp32 (in_data),
        .fp8  (w_cvt)
    );

    assign w_last_lane = (r_idx == c_LAST_IDX);
    assign w_out_free  = !r_out_valid || out_ready;

    // Only the final lane needs to wait on the output register; earlier
    // lanes keep filling the buffer while the output is blocked.
    assign in_ready    = !(w_last_lane && r_out_valid && !out_ready);
    assign w_accept    = in_valid && in_ready;

    // A flush seen while the output is blocked is remembered and applied
    // once the output frees; an empty buffer never produces a vector.
    assign w_flush_req = flush || r_flush_pend;
    assign w_has_data  = (r_idx != '0) || w_accept;
    assign w_close     = w_out_free &&
                         ((w_accept && w_last_lane) || (w_flush_req && w_has_data));

    // Buffer image including the lane written this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_buf_next[gi] = (w_accept && (r_idx == c_IDX_W'(gi))) ? w_cvt : r_buf[gi];
            assign w_buf_flat[gi*FP8_W +: FP8_W] = w_buf_next[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_close) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_buf_flat;
                r_out_last  <= w_flush_req;
                r_idx       <= '0;
                for (int i = 0; i < LANES; i++) begin
                    r_buf[i] <= '0;
                end
            end else begin
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_idx <= r_idx + c_IDX_W'(1);
                    for (int i = 0; i < LANES; i++) begin
                        r_buf[i] <= w_buf_next[i];
                    end
                end
            end

            if (w_out_free) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : fp32_to_fp8_packer
`default_nettype wire
